// File: rtl/tx_trans_framer_if.sv
// Byte-stream output bus of the transmit framer (AXI-Stream style, no tkeep/tuser).
interface tx_trans_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_trans_framer.sv
// Buffers TxMem 4-byte words and emits framed packets:
// A5 5A SEQ payload CRC-8(0x07) over SEQ+payload.
module tx_trans_framer #(
    parameter int unsigned WORDS_PER_PKT = 8,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              TransValid,
    input  logic [7:0]        Trans0Data,
    input  logic [7:0]        Trans1Data,
    input  logic [7:0]        Trans2Data,
    input  logic [7:0]        Trans3Data,
    input  logic              ClrErr,
    tx_trans_framer_if.master m_axis,
    output logic              OvfErr,
    output logic [15:0]       PktCnt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned WW = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PKT_C     = (AW+1)'(WORDS_PER_PKT);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_PKT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC0,
        SYNC1,
        SEQ,
        DATA,
        CRC
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    byte_idx;
    logic [WW-1:0] word_idx;
    logic [7:0]    seq, crc;
    logic [31:0]   head;
    logic [7:0]    head_byte;
    logic [7:0]    tdata;
    logic          tvalid, tlast;
    logic          hs, pop, wr_en, drop;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    assign head  = mem[rd_ptr];
    assign hs    = tvalid & m_axis.tready;
    assign pop   = hs && (state == DATA) && (byte_idx == 2'd3);
    // A full FIFO still takes the word when the head is leaving this cycle.
    assign wr_en = TransValid && ((count < DEPTH_C) || pop);
    assign drop  = TransValid && !wr_en;

    always_comb begin
        head_byte = head[7:0];
        case (byte_idx)
            2'd0: head_byte = head[7:0];
            2'd1: head_byte = head[15:8];
            2'd2: head_byte = head[23:16];
            2'd3: head_byte = head[31:24];
            default: head_byte = head[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tvalid   = 1'b0;
        tdata    = '0;
        tlast    = 1'b0;
        case (state)
            IDLE: begin
                if (count >= PKT_C) state_nx = SYNC0;
            end
            SYNC0: begin
                tvalid = 1'b1;
                tdata  = 8'hA5;
                if (m_axis.tready) state_nx = SYNC1;
            end
            SYNC1: begin
                tvalid = 1'b1;
                tdata  = 8'h5A;
                if (m_axis.tready) state_nx = SEQ;
            end
            SEQ: begin
                tvalid = 1'b1;
                tdata  = seq;
                if (m_axis.tready) state_nx = DATA;
            end
            DATA: begin
                tvalid = 1'b1;
                tdata  = head_byte;
                if (m_axis.tready && (byte_idx == 2'd3) && (word_idx == LAST_WORD)) state_nx = CRC;
            end
            CRC: begin
                tvalid = 1'b1;
                tdata  = crc;
                tlast  = 1'b1;
                if (m_axis.tready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m_axis.tdata  = tdata;
    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tlast;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {Trans3Data, Trans2Data, Trans1Data, Trans0Data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx <= '0;
            word_idx <= '0;
            seq      <= '0;
            crc      <= '0;
            PktCnt   <= '0;
            OvfErr   <= 1'b0;
        end else begin
            if (hs && (state == DATA)) begin
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 2'd3) begin
                    word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;
                end
            end
            if (state == SYNC1) begin
                crc <= '0;
            end else if (hs && ((state == SEQ) || (state == DATA))) begin
                crc <= crc8_step(crc, tdata);
            end
            if (hs && (state == CRC)) begin
                seq    <= seq + 1'b1;
                PktCnt <= PktCnt + 1'b1;
            end
            if (drop) begin
                OvfErr <= 1'b1;
            end else if (ClrErr) begin
                OvfErr <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tx_trans_framer.md
# tx_trans_framer

Downstream packetiser for the TxMem transmit word stream. It buffers each `TransValid` 4-byte word (`Trans0Data`..`Trans3Data`) in a small FIFO. Once a full payload is buffered, it emits a framed byte packet over an AXI-Stream-style byte interface: sync header, sequence number, payload and CRC-8. The output feeds the radio/SPI link serialiser and reports overflow and packet statistics to the control plane.

## Interface
Parameters:
- `WORDS_PER_PKT`, default 8: 32-bit words per packet payload (≥1, ≤ `FIFO_DEPTH`).
- `FIFO_DEPTH`, default 16: input FIFO depth in words, power of two.

Ports:
- `clk`  in  1  single clock (same as TxMem `Cclk`).
- `rstn`  in  1  asynchronous active-low reset.
- `TransValid`  in  1  one-cycle strobe; the 4 data bytes are valid this cycle.
- `Trans0Data`  in  8  word byte 0, transmitted first.
- `Trans1Data`  in  8  word byte 1.
- `Trans2Data`  in  8  word byte 2.
- `Trans3Data`  in  8  word byte 3, transmitted last.
- `ClrErr`  in  1  clears `OvfErr` (level, synchronous).
- `m_axis_tdata`  out  8  packet byte.
- `m_axis_tvalid`  out  1  byte valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  marks the CRC byte, the last byte of the packet.
- `OvfErr`  out  1  sticky: a word was dropped because the FIFO was full.
- `PktCnt`  out  16  packets completed, wraps.

## Operation
- Packet format: `0xA5`, `0x5A`, SEQ, then `WORDS_PER_PKT`×{B0,B1,B2,B3}, then CRC. Length is 4·`WORDS_PER_PKT`+4 bytes (36 at default).
- CRC-8 uses polynomial x⁸+x²+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR. It covers SEQ and all payload bytes, not the sync bytes.
- SEQ starts at 0 after reset. It increments by 1 after each packet's CRC byte is accepted and wraps 255→0.
- FIFO write:
  - On `TransValid`, the word is written if count < `FIFO_DEPTH`.
  - If count == `FIFO_DEPTH` and a pop occurs the same cycle, the write is accepted.
  - Otherwise the word is dropped and `OvfErr` is set.
- `OvfErr`: `ClrErr` clears it. If `ClrErr` and a drop happen in the same cycle, set wins.
- FSM states: IDLE, SYNC0, SYNC1, SEQ, DATA, CRC.
  - IDLE→SYNC0 when FIFO count ≥ `WORDS_PER_PKT`.
  - SYNC0→SYNC1→SEQ→DATA, each on handshake (`m_axis_tvalid` & `m_axis_tready`).
  - DATA advances a byte index 0..3 per handshake. The FIFO pops on the handshake of B3. DATA→CRC after the B3 handshake of word `WORDS_PER_PKT`−1.
  - CRC→IDLE on handshake. On that transition SEQ and `PktCnt` increment.
- Because entry into a packet requires all payload words buffered, DATA never stalls on an empty FIFO. `m_axis_tvalid` stays high for the whole packet.
- AXI rules:
  - `m_axis_tdata` and `m_axis_tlast` are stable while `m_axis_tvalid` & !`m_axis_tready`.
  - `m_axis_tvalid` never drops mid-packet.
  - `m_axis_tlast` is high only on the CRC byte.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0x00, `m_axis_tlast`=0, `OvfErr`=0, `PktCnt`=0. Also FIFO empty, SEQ=0, CRC=0, FSM=IDLE.
- FIFO write latency: a word written at edge N is counted at edge N. It is eligible for packet start at edge N+1.
- Start latency: `m_axis_tvalid` rises with `m_axis_tdata`=0xA5 at the edge following the edge where the count first reaches `WORDS_PER_PKT` in IDLE.
- With `m_axis_tready` held high:
  - One byte per cycle; a packet takes 4·`WORDS_PER_PKT`+4 consecutive cycles.
  - At least one IDLE cycle separates packets. `m_axis_tvalid`=0 for exactly one cycle when the next packet is already buffered.
- CRC register: reset to 0 in SYNC1. It is updated with each accepted SEQ/payload byte and is presented as the CRC byte.
- Asynchronous reset mid-packet aborts immediately. All state returns to reset values, and buffered words and the partial packet are discarded.

## Test plan
- Basic packet: 8 `TransValid` words 0x03020100, 0x07060504, …, `ready`=1. Required response:
  - 36 bytes: A5 5A 00 00 01 02 … 1F, then CRC-8 matching the model.
  - `tlast` only on byte 36; `PktCnt`=1.
- Backpressure: same stimulus, `m_axis_tready` toggled pseudo-randomly. Required response:
  - Identical byte sequence.
  - `tdata`/`tlast` held during stalls; no `tvalid` gaps inside the packet.
- Overflow: `ready`=0, 17 consecutive `TransValid` writes. Required response:
  - `OvfErr`=1 after the 17th write.
  - After releasing `ready`, exactly 2 packets emerge, carrying words 1–16.
  - `ClrErr` pulse returns `OvfErr` to 0.
- Full + pop simultaneous: FIFO at 16 words, `TransValid` on the same cycle as the B3 handshake of a word. Required response: word accepted, `OvfErr` stays 0.
- SEQ wrap: 257 packets streamed. Required response: SEQ bytes 00..FF then 00; `PktCnt`=257.
- Reset mid-packet: `rstn` low during DATA byte 10. Required response:
  - All outputs at reset values immediately.
  - After release plus 8 new words, the packet starts with SEQ=00 and its CRC is correct.
